fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage directly upstream of the F/D pipeline buffer. Owns the PC register, issues word reads to instruction memory over a req/ack handshake, and presents `incPC_F`, `instWord_F` and `noop_F` to the F/D buffer. Absorbs variable memory latency, downstream stalls and branch redirects, including redirects that arrive while a read is in flight.

## Interface
- `DBITS`, 32: address/data width.
- `START_PC`, 32'h0000_0040: first fetch address after reset.
- `NOP_WORD`, 32'h2300_0000: instruction word driven whenever no valid instruction is presented.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `stall_F` in 1: F/D buffer not writing this cycle (inverse of its `wrtEn`).
- `redirect_en` in 1: branch/jump resolved taken or mispredicted; overrides all else.
- `redirect_pc` in DBITS: redirect target; bits [1:0] ignored (treated as 0).
- `imem_req` out 1: read request; held high until ack.
- `imem_addr` out DBITS: word-aligned address; stable while `imem_req` is high.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` valid this cycle. Ignored when `imem_req` is low.
- `imem_rdata` in DBITS: instruction word.
- `incPC_F` out DBITS: address of presented instruction + 4.
- `instWord_F` out DBITS: presented instruction, or `NOP_WORD`.
- `noop_F` out 1: 1 = presented word is a bubble.

## Operation
- Registers: `reqAddr` (in-flight/held address), `pendPC` (next address after a redirect during DRAIN), `holdWord`, FSM state.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: reset state; `imem_req`=0. Next cycle → FETCH.
- FETCH: `imem_req`=1, `imem_addr`=`reqAddr`. Valid instruction presented when `imem_ack`=1 (`instWord_F`=`imem_rdata`, `noop_F`=0).
  - ack & !stall_F: accepted; `reqAddr` ← `reqAddr`+4; stay FETCH.
  - ack & stall_F: `holdWord` ← `imem_rdata`; → HOLD.
  - no ack: stay FETCH, bubble presented.
- HOLD: `imem_req`=0; presents `holdWord`, `noop_F`=0. On !stall_F: `reqAddr` ← `reqAddr`+4, → FETCH.
- DRAIN: `imem_req`=1 at old `reqAddr` (handshake must complete); bubble presented. On ack: data discarded, `reqAddr` ← `pendPC`, → FETCH.
- Redirect (`redirect_en`=1), highest priority, any state except IDLE:
  - `noop_F` forced 1 that cycle; any ack data that cycle discarded.
  - FETCH without ack → DRAIN, `pendPC` ← target.
  - FETCH with ack, HOLD → FETCH, `reqAddr` ← target.
  - DRAIN without ack → stay DRAIN, `pendPC` ← newest target; DRAIN with ack → FETCH, `reqAddr` ← target.
  - In IDLE: `reqAddr` ← target, → FETCH.
- Bubble outputs: `instWord_F`=`NOP_WORD`, `noop_F`=1, `incPC_F`=`reqAddr`+4.
- Arithmetic: all +4 modulo 2^DBITS; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: state IDLE, `reqAddr`=`START_PC`, `imem_req`=0, `imem_addr`=`START_PC`, `noop_F`=1, `instWord_F`=`NOP_WORD`, `incPC_F`=`START_PC`+4.
- Reset mid-read: outstanding request abandoned; memory must drop it on reset.
- `imem_req`, `imem_addr` are registered-state decodes (no input-to-output path). `instWord_F`/`noop_F` are combinational from `imem_ack`/`imem_rdata`/`redirect_en`; the F/D buffer registers them.
- Zero-wait memory (ack in first req cycle): one instruction per cycle, no bubbles.
- Redirect latency: target request issued the cycle after `redirect_en` (FETCH/HOLD/IDLE); after DRAIN, the cycle after the stale ack.
- Never more than one request outstanding.

## Structure
- Shared package: state enum, `NOP_WORD`, `START_PC` defaults, shared with F/D buffer and hazard unit.
- Sub-module `fetch_ctrl`: FSM (state, next-state, `imem_req`, load/select strobes). Datapath (`reqAddr`, `pendPC`, `holdWord`, output muxes) in `fetch_stage`.

## Test plan
- Reset then release, zero-wait memory returning addr-as-data: `imem_addr` 0x40, 0x44, 0x48 on consecutive cycles; `incPC_F` 0x44, 0x48, 0x4C; `noop_F`=0 from first ack.
- 3-cycle memory latency: two bubbles (`instWord_F`=32'h2300_0000, `noop_F`=1) per instruction; `imem_addr` stable while waiting.
- Ack at 0x48 with `stall_F`=1 for 2 cycles: HOLD presents 0x48 word all 3 cycles, `imem_req`=0; after release next request is 0x4C.
- `redirect_en` to 0x200 during pending 0x50 read (ack 2 cycles later): DRAIN keeps `imem_addr`=0x50, stale data never shown with `noop_F`=0; next request 0x200.
- Second redirect to 0x300 while in DRAIN, and redirect coinciding with ack: only 0x300 fetched; coincident ack data dropped, `noop_F`=1.
- Redirect to 0xFFFF_FFFE: `imem_addr`=0xFFFF_FFFC, `incPC_F`=0 on accept, next fetch at 0x0; reset asserted mid-DRAIN returns all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: fetch FSM states, address-select codes and reset defaults shared with F/D buffer and hazard unit
package fetch_stage_pkg;
   localparam int          DBITS_DEF    = 32;
   localparam logic [31:0] START_PC_DEF = 32'h0000_0040;
   localparam logic [31:0] NOP_WORD_DEF = 32'h2300_0000;
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} fetch_state_e;
   typedef enum logic [1:0] {ADDR_KEEP, ADDR_INC, ADDR_TGT, ADDR_PEND} addr_sel_e;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/ack read bus
interface fetch_stage_if #(parameter int DBITS = 32);
   logic             imem_req;
   logic [DBITS-1:0] imem_addr;
   logic             imem_ack;
   logic [DBITS-1:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch FSM producing the memory request and datapath load/select strobes
module fetch_ctrl
   import fetch_stage_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      stall_F,
   input  logic      redirect_en,
   input  logic      imem_ack,
   output logic      imem_req,
   output addr_sel_e addr_sel,
   output logic      ld_pend,
   output logic      ld_hold,
   output logic      valid,
   output logic      sel_hold
);
   fetch_state_e state, state_nx;
   logic         ack;

   // state register; reset abandons any in-flight read
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nx;

   // next state and strobes; a redirect outranks everything and always kills the presented word
   always_comb begin
      state_nx = state;
      addr_sel = ADDR_KEEP;
      ld_pend  = 1'b0;
      ld_hold  = 1'b0;
      valid    = 1'b0;
      sel_hold = 1'b0;
      imem_req = (state == FETCH) || (state == DRAIN);
      ack      = imem_ack && imem_req;
      if (redirect_en) begin
         if (state == FETCH && !ack) begin
            state_nx = DRAIN;
            ld_pend  = 1'b1;
         end else if (state == DRAIN && !ack) ld_pend = 1'b1;
         else begin
            state_nx = FETCH;
            addr_sel = ADDR_TGT;
         end
      end else
         case (state)
            IDLE:  state_nx = FETCH;
            FETCH: if (ack) begin
               valid = 1'b1;
               if (stall_F) begin
                  ld_hold  = 1'b1;
                  state_nx = HOLD;
               end else addr_sel = ADDR_INC;
            end
            HOLD: begin
               valid    = 1'b1;
               sel_hold = 1'b1;
               if (!stall_F) begin
                  addr_sel = ADDR_INC;
                  state_nx = FETCH;
               end
            end
            DRAIN: if (ack) begin
               addr_sel = ADDR_PEND;
               state_nx = FETCH;
            end
            default: ;
         endcase
   end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem request datapath and F/D output muxing
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int               DBITS    = DBITS_DEF,
   parameter logic [DBITS-1:0] START_PC = DBITS'(START_PC_DEF),
   parameter logic [DBITS-1:0] NOP_WORD = DBITS'(NOP_WORD_DEF)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_F,
   input  logic             redirect_en,
   input  logic [DBITS-1:0] redirect_pc,
   fetch_stage_if.master    imem,
   output logic [DBITS-1:0] incPC_F,
   output logic [DBITS-1:0] instWord_F,
   output logic             noop_F
);
   logic [DBITS-1:0] req_addr, pend_pc, hold_word, tgt, inc_pc, addr_nx;
   addr_sel_e        addr_sel;
   logic             ld_pend, ld_hold, valid, sel_hold;

   fetch_ctrl u_ctrl (
      .clk, .reset, .stall_F, .redirect_en,
      .imem_ack (imem.imem_ack),
      .imem_req (imem.imem_req),
      .addr_sel, .ld_pend, .ld_hold, .valid, .sel_hold
   );

   assign tgt     = redirect_pc & ~DBITS'(3);
   assign inc_pc  = req_addr + DBITS'(4);
   assign addr_nx = addr_sel == ADDR_INC  ? inc_pc  :
                    addr_sel == ADDR_TGT  ? tgt     :
                    addr_sel == ADDR_PEND ? pend_pc : req_addr;

   // request address, post-drain target and stalled instruction word
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         req_addr  <= START_PC;
         pend_pc   <= START_PC;
         hold_word <= NOP_WORD;
      end else begin
         req_addr  <= addr_nx;
         pend_pc   <= ld_pend ? tgt : pend_pc;
         hold_word <= ld_hold ? imem.imem_rdata : hold_word;
      end

   assign imem.imem_addr = req_addr;
   assign incPC_F        = inc_pc;
   assign noop_F         = !valid;
   assign instWord_F     = !valid ? NOP_WORD : sel_hold ? hold_word : imem.imem_rdata;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a latency-programmable addr-as-data memory
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h2300_0000;
   logic        clk = 1'b0, reset = 1'b1, stall_F = 1'b0, redirect_en = 1'b0, noop_F;
   logic [31:0] redirect_pc = '0, incPC_F, instWord_F;
   int          lat = 0, cnt = 0, n_cmp = 0, n_err = 0;

   fetch_stage_if #(.DBITS(32)) imem ();

   fetch_stage dut (
      .clk, .reset, .stall_F, .redirect_en, .redirect_pc,
      .imem (imem), .incPC_F, .instWord_F, .noop_F
   );

   always #5 clk = ~clk;

   assign imem.imem_ack   = imem.imem_req && (cnt == lat);
   assign imem.imem_rdata = imem.imem_addr;

   // memory model: counts wait cycles of the current request
   always @(posedge clk or negedge reset)
      if (!reset) cnt <= 0;
      else        cnt <= (!imem.imem_req || imem.imem_ack) ? 0 : cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic obs(input string tag, input logic req, input logic [31:0] addr,
                      input logic noop, input logic [31:0] inst, input logic [31:0] inc);
      check({tag, ".req"},  {31'd0, imem.imem_req}, {31'd0, req});
      check({tag, ".addr"}, imem.imem_addr, addr);
      check({tag, ".noop"}, {31'd0, noop_F}, {31'd0, noop});
      check({tag, ".inst"}, instWord_F, inst);
      check({tag, ".inc"},  incPC_F, inc);
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 reset = 1'b0;
      #1 obs("rst0", 0, 32'h40, 1, NOP, 32'h44);
      nxt(); reset = 1'b1;
      #1 obs("idle", 0, 32'h40, 1, NOP, 32'h44);
      nxt(); #1 obs("z0", 1, 32'h40, 0, 32'h40, 32'h44);
      nxt(); #1 obs("z1", 1, 32'h44, 0, 32'h44, 32'h48);
      nxt(); stall_F = 1'b1;
      #1 obs("z2", 1, 32'h48, 0, 32'h48, 32'h4C);
      nxt(); #1 obs("h1", 0, 32'h48, 0, 32'h48, 32'h4C);
      nxt(); stall_F = 1'b0; lat = 2;
      #1 obs("h2", 0, 32'h48, 0, 32'h48, 32'h4C);
      nxt(); #1 obs("l0", 1, 32'h4C, 1, NOP, 32'h50);
      nxt(); #1 obs("l1", 1, 32'h4C, 1, NOP, 32'h50);
      nxt(); #1 obs("l2", 1, 32'h4C, 0, 32'h4C, 32'h50);
      nxt(); redirect_en = 1'b1; redirect_pc = 32'h200;
      #1 obs("r0", 1, 32'h50, 1, NOP, 32'h54);
      nxt(); redirect_pc = 32'h300;
      #1 obs("d1", 1, 32'h50, 1, NOP, 32'h54);
      nxt(); redirect_en = 1'b0;
      #1 obs("d2", 1, 32'h50, 1, NOP, 32'h54);
      nxt(); #1 obs("t0", 1, 32'h300, 1, NOP, 32'h304);
      nxt(); #1 obs("t1", 1, 32'h300, 1, NOP, 32'h304);
      nxt(); redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      #1 obs("rc", 1, 32'h300, 1, NOP, 32'h304);
      nxt(); redirect_en = 1'b0; lat = 0;
      #1 obs("w0", 1, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0);
      nxt(); lat = 2; redirect_en = 1'b1; redirect_pc = 32'h100;
      #1 obs("w1", 1, 32'h0, 1, NOP, 32'h4);
      nxt(); redirect_en = 1'b0;
      #1 obs("dr", 1, 32'h0, 1, NOP, 32'h4);
      #2 reset = 1'b0;
      #1 obs("rstd", 0, 32'h40, 1, NOP, 32'h44);
      nxt(); #1 obs("rsth", 0, 32'h40, 1, NOP, 32'h44);
      nxt(); reset = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h80; lat = 0;
      #1 obs("ir", 0, 32'h40, 1, NOP, 32'h44);
      nxt(); redirect_en = 1'b0;
      #1 obs("i0", 1, 32'h80, 0, 32'h80, 32'h84);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
